// File: rtl/fp_align_add.sv
// Front end of the FP adder: unpack, magnitude-order, align and add/subtract over two register stages.
// Optional NaN/Inf detection is compiled in with `define FP_ADD_SPECIAL_EN.
module fp_align_add #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   op_a,
    input  logic [EXP_W+FRAC_W:0]   op_b,
    input  logic                    op_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FRAC_W+1:0]       mant_sum,
    output logic [EXP_W-1:0]        exp_larger,
    output logic                    sign_out
`ifdef FP_ADD_SPECIAL_EN
    ,
    output logic                    special_flag,
    output logic [EXP_W+FRAC_W:0]   special_res
`endif
);
    localparam int MANT_W = FRAC_W + 1;
    localparam int SUM_W  = FRAC_W + 2;
    localparam int OP_W   = 1 + EXP_W + FRAC_W;
    localparam int SH_W   = $clog2(SUM_W + 1);

    logic              v1_r, v2_r, en1_s, en2_s;
    logic              sign_a_s, sign_b_s, eff_sub_s, a_larger_s;
    logic [EXP_W-1:0]  exp_a_s, exp_b_s, eexp_a_s, eexp_b_s, eexp_l_s, eexp_s_s, diff_s, exp_l_s;
    logic [FRAC_W-1:0] frac_a_s, frac_b_s;
    logic [MANT_W-1:0] mant_a_s, mant_b_s, mant_l_s, mant_s_s;
    logic [SH_W-1:0]   shift_s;
    logic              sign_l_s;

    logic [MANT_W-1:0] mant_l_r, mant_s_r;
    logic [SH_W-1:0]   shift_r;
    logic              eff_sub_r, sign_l_r;
    logic [EXP_W-1:0]  exp_l_r;

    logic [SUM_W-1:0]  s_al_s, sum_s;
    logic              sign_res_s;
    logic [SUM_W-1:0]  mant_sum_r;
    logic [EXP_W-1:0]  exp_larger_r;
    logic              sign_out_r;

    assign en2_s     = !v2_r || out_ready;
    assign en1_s     = !v1_r || en2_s;
    assign in_ready  = en1_s;
    assign out_valid = v2_r;
    assign mant_sum  = mant_sum_r;
    assign exp_larger = exp_larger_r;
    assign sign_out  = sign_out_r;

    assign sign_a_s  = op_a[OP_W-1];
    assign sign_b_s  = op_b[OP_W-1] ^ op_sub;
    assign eff_sub_s = sign_a_s ^ sign_b_s;
    assign exp_a_s   = op_a[OP_W-2 -: EXP_W];
    assign exp_b_s   = op_b[OP_W-2 -: EXP_W];
    assign frac_a_s  = op_a[FRAC_W-1:0];
    assign frac_b_s  = op_b[FRAC_W-1:0];
    // Denormals carry no hidden bit but share the exponent weight of the smallest normal.
    assign mant_a_s  = {(exp_a_s != {EXP_W{1'b0}}), frac_a_s};
    assign mant_b_s  = {(exp_b_s != {EXP_W{1'b0}}), frac_b_s};
    assign eexp_a_s  = (exp_a_s == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_a_s;
    assign eexp_b_s  = (exp_b_s == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : exp_b_s;
    assign a_larger_s = {eexp_a_s, frac_a_s} >= {eexp_b_s, frac_b_s};

    // Stage 1 operand ordering and saturated alignment distance.
    always_comb begin
        if (a_larger_s) begin
            mant_l_s = mant_a_s;
            mant_s_s = mant_b_s;
            eexp_l_s = eexp_a_s;
            eexp_s_s = eexp_b_s;
            exp_l_s  = exp_a_s;
            sign_l_s = sign_a_s;
        end else begin
            mant_l_s = mant_b_s;
            mant_s_s = mant_a_s;
            eexp_l_s = eexp_b_s;
            eexp_s_s = eexp_a_s;
            exp_l_s  = exp_b_s;
            sign_l_s = sign_b_s;
        end
        diff_s = eexp_l_s - eexp_s_s;
        if (diff_s >= EXP_W'(SUM_W)) begin
            shift_s = SH_W'(SUM_W);
        end else begin
            shift_s = diff_s[SH_W-1:0];
        end
    end

    // Stage 1 pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            mant_l_r  <= {MANT_W{1'b0}};
            mant_s_r  <= {MANT_W{1'b0}};
            shift_r   <= {SH_W{1'b0}};
            eff_sub_r <= 1'b0;
            exp_l_r   <= {EXP_W{1'b0}};
            sign_l_r  <= 1'b0;
        end else if (en1_s) begin
            v1_r      <= in_valid;
            mant_l_r  <= mant_l_s;
            mant_s_r  <= mant_s_s;
            shift_r   <= shift_s;
            eff_sub_r <= eff_sub_s;
            exp_l_r   <= exp_l_s;
            sign_l_r  <= sign_l_s;
        end
    end

    // Stage 2 alignment (truncating) and magnitude add/subtract; L >= S so no borrow out.
    always_comb begin
        if (shift_r >= SH_W'(SUM_W)) begin
            s_al_s = {SUM_W{1'b0}};
        end else begin
            s_al_s = {1'b0, mant_s_r} >> shift_r;
        end
        if (eff_sub_r) begin
            sum_s = {1'b0, mant_l_r} - s_al_s;
        end else begin
            sum_s = {1'b0, mant_l_r} + s_al_s;
        end
        if (eff_sub_r && (sum_s == {SUM_W{1'b0}})) begin
            sign_res_s = 1'b0;
        end else begin
            sign_res_s = sign_l_r;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r         <= 1'b0;
            mant_sum_r   <= {SUM_W{1'b0}};
            exp_larger_r <= {EXP_W{1'b0}};
            sign_out_r   <= 1'b0;
        end else if (en2_s) begin
            v2_r         <= v1_r;
            mant_sum_r   <= sum_s;
            exp_larger_r <= exp_l_r;
            sign_out_r   <= sign_res_s;
        end
    end

`ifdef FP_ADD_SPECIAL_EN
    logic            nan_a_s, nan_b_s, inf_a_s, inf_b_s, sflag_s;
    logic [OP_W-1:0] sres_s, sres1_r, sres2_r;
    logic            sflag1_r, sflag2_r;

    assign nan_a_s = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s != {FRAC_W{1'b0}});
    assign nan_b_s = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s != {FRAC_W{1'b0}});
    assign inf_a_s = (exp_a_s == {EXP_W{1'b1}}) && (frac_a_s == {FRAC_W{1'b0}});
    assign inf_b_s = (exp_b_s == {EXP_W{1'b1}}) && (frac_b_s == {FRAC_W{1'b0}});

    // NaN or opposing infinities give the canonical quiet NaN; a lone infinity passes through.
    always_comb begin
        if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && eff_sub_s)) begin
            sflag_s = 1'b1;
            sres_s  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        end else if (inf_a_s) begin
            sflag_s = 1'b1;
            sres_s  = {sign_a_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (inf_b_s) begin
            sflag_s = 1'b1;
            sres_s  = {sign_b_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            sflag_s = 1'b0;
            sres_s  = {OP_W{1'b0}};
        end
    end

    // Special-case result rides the same two stages as the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sflag1_r <= 1'b0;
            sres1_r  <= {OP_W{1'b0}};
            sflag2_r <= 1'b0;
            sres2_r  <= {OP_W{1'b0}};
        end else begin
            if (en1_s) begin
                sflag1_r <= sflag_s;
                sres1_r  <= sres_s;
            end
            if (en2_s) begin
                sflag2_r <= sflag1_r;
                sres2_r  <= sres1_r;
            end
        end
    end

    assign special_flag = sflag2_r;
    assign special_res  = sres2_r;
`endif
endmodule

// File: tb/tb_fp_align_add.sv
// Scoreboard bench for fp_align_add: randomized and directed operand pairs checked against a
// behavioural model, with stall, backpressure and mid-flight reset scenarios.
`timescale 1ns/1ps
module tb_fp_align_add;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] mant_sum;
    logic [7:0]  exp_larger;
    logic        sign_out;
`ifdef FP_ADD_SPECIAL_EN
    logic        special_flag;
    logic [31:0] special_res;
`endif

    typedef struct {
        logic [24:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        sflag;
        logic [31:0] sres;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rand_ready_en = 1'b0;

    fp_align_add dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .mant_sum(mant_sum), .exp_larger(exp_larger), .sign_out(sign_out)
`ifdef FP_ADD_SPECIAL_EN
        , .special_flag(special_flag), .special_res(special_res)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: real-number style rules on integer magnitudes.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t r;
        longint ea, eb, fa, fb, ma, mb, xa, xb, ml, ms, el, sh, sal, sum;
        logic sa, sb, effsub, sl, nan_a, nan_b, inf_a, inf_b;
        ea = longint'(a[30:23]); eb = longint'(b[30:23]);
        fa = longint'(a[22:0]);  fb = longint'(b[22:0]);
        sa = a[31]; sb = b[31] ^ sub; effsub = sa ^ sb;
        ma = (ea != 0) ? fa + 64'd8388608 : fa;
        mb = (eb != 0) ? fb + 64'd8388608 : fb;
        xa = (ea == 0) ? 64'd1 : ea;
        xb = (eb == 0) ? 64'd1 : eb;
        if (xa * 64'd8388608 + fa >= xb * 64'd8388608 + fb) begin
            ml = ma; ms = mb; el = ea; sl = sa; sh = xa - xb;
        end else begin
            ml = mb; ms = ma; el = eb; sl = sb; sh = xb - xa;
        end
        sal = (sh >= 25) ? 64'd0 : (ms >> sh);
        sum = effsub ? ml - sal : ml + sal;
        r.mant = sum[24:0];
        r.exp  = el[7:0];
        r.sign = (effsub && sum == 0) ? 1'b0 : sl;
        nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
        if (nan_a || nan_b || (inf_a && inf_b && effsub)) begin
            r.sflag = 1'b1; r.sres = 32'h7FC00000;
        end else if (inf_a) begin
            r.sflag = 1'b1; r.sres = {sa, 31'h7F800000};
        end else if (inf_b) begin
            r.sflag = 1'b1; r.sres = {sb, 31'h7F800000};
        end else begin
            r.sflag = 1'b0; r.sres = 32'h0;
        end
        return r;
    endfunction

    // Directed expectation: data fields from hand-derived constants, special fields from the model.
    function automatic exp_t mk(input logic [24:0] m, input logic [7:0] e, input logic s,
                                input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t r;
        r = model(a, b, sub);
        r.mant = m; r.exp = e; r.sign = s;
        return r;
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: r = $urandom;
            1: begin
                e = other[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                r = {r[31], e, r[22:0]};
            end
            2: r = {r[31], 8'h00, ($urandom_range(0, 1) == 0) ? 23'h0 : r[22:0]};
            3: r = {r[31], other[30:0]};
            4: r = {r[31], 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : r[22:0]};
            default: begin
                e = 8'($urandom_range(100, 150));
                r = {r[31], e, r[22:0]};
            end
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e);
        bit acc;
        acc = 1'b0;
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            #1;
            if (in_ready) begin
                sb_q.push_back(e);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout in_ready stayed 0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic sub);
        send(a, b, sub, model(a, b, sub));
    endtask

    // Random backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pop and compare on every output transfer; check stability while stalled.
    initial begin
        bit          prev_stall;
        logic [33:0] prev_data;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = 34'h0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'({mant_sum, exp_larger, sign_out}), 64'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_out got mant=%0h with empty scoreboard, required no output", mant_sum);
                    end else begin
                        e = sb_q.pop_front();
                        check("mant_sum", 64'(mant_sum), 64'(e.mant));
                        check("exp_larger", 64'(exp_larger), 64'(e.exp));
                        check("sign_out", 64'(sign_out), 64'(e.sign));
`ifdef FP_ADD_SPECIAL_EN
                        check("special_flag", 64'(special_flag), 64'(e.sflag));
                        check("special_res", 64'(special_res), 64'(e.sres));
`endif
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = {mant_sum, exp_larger, sign_out};
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        int          waited;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_mant_sum", 64'(mant_sum), 64'd0);
        check("reset_exp", 64'(exp_larger), 64'd0);
        @(negedge clk);

        out_ready = 1'b1;
        send(32'h3F800000, 32'h3F800000, 1'b0, mk(25'h1000000, 8'd127, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0));
        send(32'h40400000, 32'h3F800000, 1'b1, mk(25'h0800000, 8'd128, 1'b0, 32'h40400000, 32'h3F800000, 1'b1));
        send(32'h3F800000, 32'h3F800000, 1'b1, mk(25'h0000000, 8'd127, 1'b0, 32'h3F800000, 32'h3F800000, 1'b1));
        send(32'h3F800000, 32'h40400000, 1'b1, mk(25'h0800000, 8'd128, 1'b1, 32'h3F800000, 32'h40400000, 1'b1));
        send(32'h3FC00000, 32'h30800000, 1'b0, mk(25'h0C00000, 8'd127, 1'b0, 32'h3FC00000, 32'h30800000, 1'b0));
        send(32'h80000000, 32'h80000000, 1'b0, mk(25'h0000000, 8'd0, 1'b1, 32'h80000000, 32'h80000000, 1'b0));
        send(32'h80000000, 32'h00000000, 1'b0, mk(25'h0000000, 8'd0, 1'b0, 32'h80000000, 32'h00000000, 1'b0));
        send(32'h00000001, 32'h00000001, 1'b0, mk(25'h0000002, 8'd0, 1'b0, 32'h00000001, 32'h00000001, 1'b0));
        send(32'h7F800000, 32'hFF800000, 1'b0, mk(25'h0000000, 8'd255, 1'b0, 32'h7F800000, 32'hFF800000, 1'b0));
        send_m(32'h7FC00001, 32'h3F800000, 1'b0);
        send_m(32'h3F800000, 32'h7F800000, 1'b1);

        // Four pairs against a stalled output: only two fit in the pipe.
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a = rnd_op(32'h40000000); b = rnd_op(a);
            op_a = a; op_b = b; op_sub = 1'b0; in_valid = 1'b1;
            #1;
            check("stall_in_ready", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
            if (in_ready) sb_q.push_back(model(a, b, 1'b0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_m(32'h41200000, 32'h3F000000, 1'b1);
        send_m(32'hC1200000, 32'h3F000000, 1'b0);

        // Reset while two results are in flight.
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        send_m(32'h40000000, 32'h40000000, 1'b0);
        send_m(32'h40800000, 32'h3F800000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("post_reset_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Randomized traffic with random gaps and backpressure.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a = rnd_op($urandom);
            b = rnd_op(a);
            send_m(a, b, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rand_ready_en = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_remaining", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
